pipe_hazard_ctrl: RTL

//  Sequences the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM) and the PC.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 40 ++++
 rtl/pipe_hazard_ctrl_if.sv | 49 ++++
 rtl/pipe_hazard_ctrl_haz_detect.sv | 21 ++
 rtl/pipe_hazard_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encodings are plain localparam vectors so older tools and
// hand-written netlists can still refer to them; the enum is built on them.
package pipe_ctrl_pkg;

    localparam int          REG_W_DEF   = 5;
    localparam int unsigned ZERO_REG    = 0;

    localparam logic [1:0]  ST_RUN      = 2'd0;
    localparam logic [1:0]  ST_LU_STALL = 2'd1;
    localparam logic [1:0]  ST_MEM_WAIT = 2'd2;

    typedef enum logic [1:0] {
        RUN      = ST_RUN,
        LU_STALL = ST_LU_STALL,
        MEM_WAIT = ST_MEM_WAIT
    } state_e;

    // One bundle of everything the controller drives into the pipeline.
    typedef struct packed {
        logic pc_en;
        logic pc_src;
        logic ifid_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_en;
        logic exmem_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_OFF    = '0;
    localparam ctrl_t CTRL_RUN    = '{pc_en: 1'b1, pc_src: 1'b0, ifid_en: 1'b1, ifid_flush: 1'b0,
                                      idex_flush: 1'b0, exmem_en: 1'b1, exmem_flush: 1'b0};
    localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, pc_src: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                      idex_flush: 1'b0, exmem_en: 1'b0, exmem_flush: 1'b0};
    localparam ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, pc_src: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
                                      idex_flush: 1'b1, exmem_en: 1'b1, exmem_flush: 1'b1};
    localparam ctrl_t CTRL_LU     = '{pc_en: 1'b0, pc_src: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                      idex_flush: 1'b1, exmem_en: 1'b1, exmem_flush: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller.
// master = pipeline datapath, slave = hazard controller.
// HAZ_PERF_CNT_EN adds the stall/flush performance counter outputs.
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rd;
    logic             mem_branch;
    logic             mem_zf;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_en;
    logic             pc_src;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_en;
    logic             exmem_flush;
    logic             mem_tmo_err;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]      stall_cyc_cnt;
    logic [31:0]      flush_cnt;
`endif

    modport master (
        output id_rs, id_rt, ex_mem_read, ex_rd, mem_branch, mem_zf, mem_req, mem_ready,
        input  pc_en, pc_src, ifid_en, ifid_flush, idex_flush, exmem_en, exmem_flush,
`ifdef HAZ_PERF_CNT_EN
        input  stall_cyc_cnt, flush_cnt,
`endif
        input  mem_tmo_err
    );

    modport slave (
        input  id_rs, id_rt, ex_mem_read, ex_rd, mem_branch, mem_zf, mem_req, mem_ready,
        output pc_en, pc_src, ifid_en, ifid_flush, idex_flush, exmem_en, exmem_flush,
`ifdef HAZ_PERF_CNT_EN
        output stall_cyc_cnt, flush_cnt,
`endif
        output mem_tmo_err
    );

endinterface

// File: rtl/pipe_hazard_ctrl_haz_detect.sv
// Load-use comparator: the load in EX writes a register the instruction in ID
// reads. Writes to the zero register never create a dependency.
module haz_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_ex_mem_read,
    output logic             o_lu_haz
);

    logic w_rd_live;

    assign w_rd_live = (i_ex_rd != REG_W'(ZERO_REG));
    assign o_lu_haz  = i_ex_mem_read & w_rd_live &
                       ((i_ex_rd == i_id_rs) | (i_ex_rd == i_id_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: drives PC / IF/ID / ID/EX / EX/MEM enables and
// flushes for memory waits, taken branches and load-use stalls (in that
// priority). Outputs are combinational from state and inputs.
// Optional macro HAZ_PERF_CNT_EN adds saturating stall/flush counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LU_STALL_CYC = 1,
    parameter int MEM_TIMEOUT  = 16,
    parameter int REG_W        = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    state_e     r_state,   w_state_nxt;
    logic [2:0] r_lu_cnt,  w_lu_cnt_nxt;
    logic [7:0] r_tmo_cnt, w_tmo_cnt_nxt;
    logic       r_tmo_err, w_tmo_err_nxt;

    logic       w_lu_haz;
    logic       w_mem_wait;
    logic       w_br_taken;
    ctrl_t      w_ctrl;

    haz_detect #(.REG_W(REG_W)) u_haz_detect (
        .i_id_rs       (bus.id_rs),
        .i_id_rt       (bus.id_rt),
        .i_ex_rd       (bus.ex_rd),
        .i_ex_mem_read (bus.ex_mem_read),
        .o_lu_haz      (w_lu_haz)
    );

    assign w_mem_wait = bus.mem_req & ~bus.mem_ready;
    assign w_br_taken = bus.mem_branch & bus.mem_zf;

    // Decode hazards into pipeline controls and the next controller state.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        w_ctrl        = CTRL_RUN;
        w_state_nxt   = r_state;
        w_lu_cnt_nxt  = r_lu_cnt;
        w_tmo_cnt_nxt = r_tmo_cnt;
        w_tmo_err_nxt = r_tmo_err;

        case (r_state)
            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    w_state_nxt   = RUN;
                    w_tmo_cnt_nxt = '0;
                end else begin
                    w_ctrl = CTRL_FREEZE;
                    // Counter parks at the limit so it can never wrap.
                    if (r_tmo_cnt != 8'(MEM_TIMEOUT))
                        w_tmo_cnt_nxt = r_tmo_cnt + 8'd1;
                    if (r_tmo_cnt >= 8'(MEM_TIMEOUT - 1))
                        w_tmo_err_nxt = 1'b1;
                end
            end
            default: begin
                // RUN and LU_STALL share the hazard priority chain.
                if (w_mem_wait) begin
                    w_ctrl        = CTRL_FREEZE;
                    w_state_nxt   = MEM_WAIT;
                    w_tmo_cnt_nxt = 8'd1;
                    w_lu_cnt_nxt  = '0;
                end else if (w_br_taken) begin
                    w_ctrl       = CTRL_BRANCH;
                    w_state_nxt  = RUN;
                    w_lu_cnt_nxt = '0;
                end else if (r_state == LU_STALL) begin
                    w_ctrl = CTRL_LU;
                    if (r_lu_cnt == 3'(LU_STALL_CYC - 1)) begin
                        w_state_nxt  = RUN;
                        w_lu_cnt_nxt = '0;
                    end else begin
                        w_lu_cnt_nxt = r_lu_cnt + 3'd1;
                    end
                end else if (w_lu_haz) begin
                    w_ctrl = CTRL_LU;
                    if (LU_STALL_CYC > 1) begin
                        w_state_nxt  = LU_STALL;
                        w_lu_cnt_nxt = 3'd1;
                    end
                end
            end
        endcase

        // Reset silences every control line, independent of state.
        if (rst)
            w_ctrl = CTRL_OFF;
    end

    // Controller state, counters and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state   <= RUN;
            r_lu_cnt  <= '0;
            r_tmo_cnt <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lu_cnt  <= w_lu_cnt_nxt;
            r_tmo_cnt <= w_tmo_cnt_nxt;
            r_tmo_err <= w_tmo_err_nxt;
        end
    end

    assign bus.pc_en       = w_ctrl.pc_en;
    assign bus.pc_src      = w_ctrl.pc_src;
    assign bus.ifid_en     = w_ctrl.ifid_en;
    assign bus.ifid_flush  = w_ctrl.ifid_flush;
    assign bus.idex_flush  = w_ctrl.idex_flush;
    assign bus.exmem_en    = w_ctrl.exmem_en;
    assign bus.exmem_flush = w_ctrl.exmem_flush;
    assign bus.mem_tmo_err = r_tmo_err;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_stall_cyc_cnt;
    logic [31:0] r_flush_cnt;

    // Saturating counters: frozen-PC cycles and taken-branch flush cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cyc_cnt <= '0;
            r_flush_cnt     <= '0;
        end else begin
            if (!w_ctrl.pc_en && (r_stall_cyc_cnt != '1))
                r_stall_cyc_cnt <= r_stall_cyc_cnt + 32'd1;
            // Only a taken branch ever flushes EX/MEM.
            if (w_ctrl.exmem_flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign bus.stall_cyc_cnt = r_stall_cyc_cnt;
    assign bus.flush_cnt     = r_flush_cnt;
`endif

endmodule
